// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared fetch/decode types and widths
package fetch_queue_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  // One fetched instruction; decode consumes the same layout.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_storage.sv
// rtl/fetch_queue_storage.sv - fetch queue entry array, one write port, async read
module fetch_queue_storage
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [PTR_WIDTH-1:0] i_waddr,
  input  fetch_entry_t         i_wdata,
  input  logic [PTR_WIDTH-1:0] i_raddr,
  output fetch_entry_t         o_rdata
);

  // Contents only matter once the control logic marks them valid, so no reset.
  fetch_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order instruction buffer between icache and decode
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic [DATA_WIDTH-1:0] i_instr,
  input  logic                  i_flush,
  output logic                  o_full,
  output logic                  o_valid,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic [DATA_WIDTH-1:0] o_instr,
  input  logic                  i_ready,
  output logic [PTR_WIDTH:0]    o_count
);

  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH:0]   count_q, count_d;
  logic                 push, pop;
  fetch_entry_t         wr_entry, head_entry;

  // Status comes purely from the registered count: no path from i_valid/i_ready.
  assign o_valid = (count_q != '0);
  assign o_full  = (count_q == (PTR_WIDTH+1)'(DEPTH));
  assign o_count = count_q;

  assign push = i_valid & ~o_full & ~i_flush;
  assign pop  = o_valid & i_ready & ~i_flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_WIDTH+1)'(1);
        2'b01:   count_d = count_q - (PTR_WIDTH+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_entry.pc    = i_pc;
  assign wr_entry.instr = i_instr;

  fetch_queue_storage #(.DEPTH(DEPTH)) u_storage (
    .clk     (clk),
    .i_we    (push),
    .i_waddr (wr_ptr_q),
    .i_wdata (wr_entry),
    .i_raddr (rd_ptr_q),
    .o_rdata (head_entry)
  );

  assign o_pc    = head_entry.pc;
  assign o_instr = head_entry.instr;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed bench with queue reference model for fetch_queue
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int PW    = $clog2(DEPTH);

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  i_valid, i_flush, i_ready;
  logic [ADDR_WIDTH-1:0] i_pc;
  logic [DATA_WIDTH-1:0] i_instr;
  logic                  o_full, o_valid;
  logic [ADDR_WIDTH-1:0] o_pc;
  logic [DATA_WIDTH-1:0] o_instr;
  logic [PW:0]           o_count;

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;
  logic [ADDR_WIDTH-1:0] fpc;
  logic [ADDR_WIDTH-1:0] exp_head;

  fetch_entry_t model_q[$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i_pc    (i_pc),
    .i_instr (i_instr),
    .i_flush (i_flush),
    .o_full  (o_full),
    .o_valid (o_valid),
    .o_pc    (o_pc),
    .o_instr (o_instr),
    .i_ready (i_ready),
    .o_count (o_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [DATA_WIDTH-1:0] instr_of(input logic [ADDR_WIDTH-1:0] pc);
    return {16'h2402, pc[15:0]};
  endfunction

  // Reference: a plain FIFO of entries, updated from the inputs seen at each edge.
  always @(posedge clk) begin
    if (rst_n) begin
      bit do_push, do_pop;
      fetch_entry_t e;
      do_push = i_valid && (model_q.size() < DEPTH) && !i_flush;
      do_pop  = (model_q.size() > 0) && i_ready && !i_flush;
      if (i_flush) model_q.delete();
      else begin
        if (do_pop) void'(model_q.pop_front());
        if (do_push) begin
          e.pc = i_pc;
          e.instr = i_instr;
          model_q.push_back(e);
        end
      end
    end
  end

  always @(negedge rst_n) model_q.delete();

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("mdl_valid", o_valid, model_q.size() != 0);
      check("mdl_full", o_full, model_q.size() == DEPTH);
      check("mdl_count", o_count, model_q.size());
      if (model_q.size() != 0) begin
        check("mdl_pc", o_pc, model_q[0].pc);
        check("mdl_instr", o_instr, model_q[0].instr);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Fetch stage stand-in: PC advances only when the queue was not full at the edge.
  task automatic fetch_cycle();
    logic f;
    f = o_full;
    @(posedge clk);
    #1;
    if (i_valid && !f) fpc = fpc + 4;
    i_pc = fpc;
    i_instr = instr_of(fpc);
  endtask

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
    i_pc = '0; i_instr = '0; fpc = '0; exp_head = '0;
    repeat (2) cycle();
    check("rst_valid", o_valid, 1'b0);
    check("rst_full", o_full, 1'b0);
    check("rst_count", o_count, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    cycle();

    // Single push
    i_valid = 1'b1; i_pc = 32'h100; i_instr = 32'h24020005;
    cycle();
    i_valid = 1'b0;
    check("single_valid", o_valid, 1'b1);
    check("single_pc", o_pc, 32'h100);
    check("single_instr", o_instr, 32'h24020005);
    check("single_count", o_count, 1);
    i_ready = 1'b1;
    cycle();
    i_ready = 1'b0;
    check("single_drain", o_count, 0);

    // Reset mid-cycle with entries present
    fpc = 32'h180; i_pc = fpc; i_instr = instr_of(fpc); i_valid = 1'b1;
    repeat (2) fetch_cycle();
    i_valid = 1'b0;
    check("pre_rst_count", o_count, 2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", o_valid, 1'b0);
    check("async_rst_full", o_full, 1'b0);
    check("async_rst_count", o_count, 0);
    cycle();
    rst_n = 1'b1;
    cycle();

    // Fill to full, refused push, then the held PC goes in exactly once
    fpc = 32'h100; i_pc = fpc; i_instr = instr_of(fpc); i_valid = 1'b1; i_ready = 1'b0;
    repeat (4) fetch_cycle();
    check("fill_full", o_full, 1'b1);
    check("fill_count", o_count, 4);
    fetch_cycle();
    check("refuse_count", o_count, 4);
    check("refuse_head", o_pc, 32'h100);
    i_ready = 1'b1;
    fetch_cycle();
    i_ready = 1'b0;
    check("pop_full_head", o_pc, 32'h104);
    check("pop_full_full", o_full, 1'b0);
    fetch_cycle();
    check("held_push_count", o_count, 4);
    i_valid = 1'b0; i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_pc", o_pc, 32'h104 + 32'(4 * k));
      cycle();
    end
    i_ready = 1'b0;
    check("drain_empty", o_count, 0);

    // Streaming at count=2 through pointer wrap
    fpc = 32'h200; i_pc = fpc; i_instr = instr_of(fpc); i_valid = 1'b1;
    repeat (2) fetch_cycle();
    check("stream_start", o_pc, 32'h200);
    exp_head = 32'h200;
    i_ready = 1'b1;
    repeat (10) begin
      fetch_cycle();
      exp_head = exp_head + 4;
      check("stream_count", o_count, 2);
      check("stream_pc", o_pc, exp_head);
    end

    // Flush with push and pop both requested
    i_ready = 1'b0;
    fetch_cycle();
    check("pre_flush_count", o_count, 3);
    i_flush = 1'b1; i_ready = 1'b1; i_valid = 1'b1;
    cycle();
    i_flush = 1'b0; i_ready = 1'b0; i_valid = 1'b0;
    check("flush_count", o_count, 0);
    check("flush_valid", o_valid, 1'b0);
    i_pc = 32'h300; i_instr = 32'h8C430000; i_valid = 1'b1;
    cycle();
    i_valid = 1'b0;
    check("post_flush_pc", o_pc, 32'h300);
    check("post_flush_instr", o_instr, 32'h8C430000);
    check("post_flush_count", o_count, 1);
    i_ready = 1'b1;
    cycle();

    // Pop on empty
    repeat (3) begin
      cycle();
      check("empty_pop_count", o_count, 0);
      check("empty_pop_valid", o_valid, 1'b0);
    end
    i_ready = 1'b0;
    i_pc = 32'h400; i_instr = 32'hDEADBEEF; i_valid = 1'b1;
    cycle();
    i_valid = 1'b0;
    check("empty_then_pc", o_pc, 32'h400);
    check("empty_then_instr", o_instr, 32'hDEADBEEF);
    check("empty_then_count", o_count, 1);
    cycle();
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
